// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - opcodes, FSM states and datapath control bundle for the multi-cycle core
package core_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } ctrl_state_t;

   typedef struct packed {
      logic alu_src;
      logic reg_write;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
      logic branch;
   } ctrl_t;

endpackage

// File: rtl/core_opcode_decode.sv
// rtl/core_opcode_decode.sv - combinational opcode to control-bundle decode
module core_opcode_decode
   import core_pkg::*;
(
   input  logic [6:0] opcode,
   output ctrl_t      ctrl,
   output logic       legal
);

   always_comb begin
      ctrl  = '0;
      legal = 1'b1;
      case (opcode)
         OPC_R: begin
            ctrl.reg_write = 1'b1;
         end
         OPC_I: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OPC_LOAD: begin
            ctrl.alu_src    = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.mem_read   = 1'b1;
         end
         OPC_STORE: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl.branch = 1'b1;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/core_control_fsm.sv
// rtl/core_control_fsm.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with bus timeout
module core_control_fsm
   import core_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic             branch,
   output logic             alu_src,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             illegal_instr,
   output logic             bus_timeout,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   localparam int              WCNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(TIMEOUT_CYCLES);
   localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);

   ctrl_state_t       state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   ctrl_t             ctrl;
   logic              legal;
   logic              wait_hit;
   logic              retire;

   core_opcode_decode u_decode (
      .opcode (opcode),
      .ctrl   (ctrl),
      .legal  (legal)
   );

   // Timeout fires only when the limit is reached and the pending ack is still absent.
   assign wait_hit = TO_EN && (wcnt_q == WAIT_LIM);

   always_comb begin
      state_d       = state_q;
      wcnt_d        = '0;
      retire        = 1'b0;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      branch        = 1'b0;
      alu_src       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      illegal_instr = 1'b0;
      bus_timeout   = 1'b0;
      halted        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end else if (wait_hit) begin
               bus_timeout = 1'b1;
               state_d     = ST_HALT;
            end else if (TO_EN) begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         ST_DECODE: begin
            if (legal) begin
               state_d = ST_EXEC;
            end else begin
               illegal_instr = 1'b1;
               state_d       = ST_FETCH;
            end
         end
         ST_EXEC: begin
            alu_src = ctrl.alu_src;
            branch  = ctrl.branch;
            if (ctrl.branch) begin
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (ctrl.mem_read || ctrl.mem_write) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req  = 1'b1;
            alu_src   = 1'b1;
            mem_read  = ctrl.mem_read;
            mem_write = ctrl.mem_write;
            if (dmem_ack) begin
               if (ctrl.mem_read) begin
                  state_d = ST_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
            end else if (wait_hit) begin
               bus_timeout = 1'b1;
               state_d     = ST_HALT;
            end else if (TO_EN) begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         ST_WB: begin
            reg_write  = ctrl.reg_write;
            mem_to_reg = ctrl.mem_to_reg;
            retire     = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wcnt_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_core_control_fsm.sv
// tb/tb_core_control_fsm.sv - randomized self-checking bench for core_control_fsm
module tb_core_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       imem_ack, dmem_ack;
   logic       imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write;
   logic       branch, alu_src, reg_write, mem_to_reg, illegal_instr, bus_timeout, halted;
   logic [3:0] instret;
   logic [12:0] outs;

   always #5 clk = ~clk;

   core_control_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .imem_ack      (imem_ack),
      .dmem_ack      (dmem_ack),
      .imem_req      (imem_req),
      .dmem_req      (dmem_req),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .branch        (branch),
      .alu_src       (alu_src),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .illegal_instr (illegal_instr),
      .bus_timeout   (bus_timeout),
      .halted        (halted),
      .instret       (instret)
   );

   assign outs = {imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, branch,
                  alu_src, reg_write, mem_to_reg, illegal_instr, bus_timeout, halted};

   localparam logic [12:0] IREQ = 13'h1000, DREQ = 13'h0800, MRD = 13'h0400, MWR = 13'h0200;
   localparam logic [12:0] IRW  = 13'h0100, PCW  = 13'h0080, BR  = 13'h0040, ALU = 13'h0020;
   localparam logic [12:0] RW   = 13'h0010, M2R  = 13'h0008, ILL = 13'h0004, TO  = 13'h0002;
   localparam logic [12:0] HLT  = 13'h0001, NONE = 13'h0000;
   localparam logic [6:0]  R_OP = 7'b0110011, I_OP = 7'b0010011, L_OP = 7'b0000011;
   localparam logic [6:0]  S_OP = 7'b0100011, B_OP = 7'b1100011;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return (op == R_OP) || (op == I_OP) || (op == L_OP) || (op == S_OP) || (op == B_OP);
   endfunction

   // One clock cycle: drive acks, compare strobes and counter mid-cycle, then account a retire.
   task automatic step(input logic ia, input logic da, input logic [12:0] exp,
                       input bit retire, input string tag);
      imem_ack = ia;
      dmem_ack = da;
      @(negedge clk);
      check({tag, " outs"}, 32'(outs), 32'(exp));
      check({tag, " instret"}, 32'(instret), 32'(model_cnt));
      @(posedge clk);
      #1;
      if (retire) model_cnt = (model_cnt + 1) % 16;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("reset outs", 32'(outs), 32'(NONE));
         check("reset instret", 32'(instret), 32'd0);
      end
      model_cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(rb(), rb(), NONE, 1'b0, "idle");
   endtask

   task automatic run_instr(input logic [6:0] opc, input int iw, input int dw);
      bit is_i, is_l, is_s, is_b;
      opcode = opc;
      is_i = (opc == I_OP);
      is_l = (opc == L_OP);
      is_s = (opc == S_OP);
      is_b = (opc == B_OP);
      for (int c = 0; c <= iw; c++)
         step(c == iw, rb(), IREQ | ((c == iw) ? (IRW | PCW) : NONE), 1'b0, "fetch");
      if (!is_legal(opc)) begin
         step(rb(), rb(), ILL, 1'b0, "decode_illegal");
         return;
      end
      step(rb(), rb(), NONE, 1'b0, "decode");
      step(rb(), rb(), ((is_i || is_l || is_s) ? ALU : NONE) | (is_b ? BR : NONE), is_b, "exec");
      if (is_b) return;
      if (is_l || is_s) begin
         for (int c = 0; c <= dw; c++)
            step(rb(), c == dw, DREQ | ALU | (is_l ? MRD : MWR), is_s && (c == dw), "mem");
      end
      if (is_s) return;
      step(rb(), rb(), RW | (is_l ? M2R : NONE), 1'b1, "wb");
   endtask

   task automatic halt_and_reset();
      for (int k = 0; k < 3; k++) step(rb(), rb(), HLT, 1'b0, "halt");
      do_reset(1);
   endtask

   initial begin
      logic [6:0] opc;
      rst_n    = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      opcode   = 7'd0;
      do_reset(3);

      run_instr(R_OP, 0, 0);
      run_instr(L_OP, 0, 3);
      run_instr(S_OP, 0, 0);
      run_instr(B_OP, 0, 0);
      run_instr(7'b1111111, 0, 0);
      run_instr(I_OP, 4, 0);
      run_instr(L_OP, 2, 4);

      for (int n = 0; n < 17; n++) run_instr(R_OP, 0, 0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0: opc = R_OP;
            1: opc = I_OP;
            2: opc = L_OP;
            3: opc = S_OP;
            4: opc = B_OP;
            default: begin
               do opc = 7'($urandom); while (is_legal(opc));
            end
         endcase
         run_instr(opc, $urandom_range(0, 4), $urandom_range(0, 4));
      end

      // Reset while a fetch is outstanding.
      opcode = L_OP;
      step(1'b0, rb(), IREQ, 1'b0, "fetch_wait");
      do_reset(2);
      run_instr(R_OP, 1, 0);

      opcode = I_OP;
      for (int c = 0; c <= 4; c++)
         step(1'b0, rb(), IREQ | ((c == 4) ? TO : NONE), 1'b0, "fetch_timeout");
      halt_and_reset();

      opcode = S_OP;
      step(1'b1, rb(), IREQ | IRW | PCW, 1'b0, "fetch");
      step(rb(), rb(), NONE, 1'b0, "decode");
      step(rb(), rb(), ALU, 1'b0, "exec");
      for (int c = 0; c <= 4; c++)
         step(rb(), 1'b0, DREQ | ALU | MWR | ((c == 4) ? TO : NONE), 1'b0, "mem_timeout");
      halt_and_reset();

      run_instr(B_OP, 0, 0);
      run_instr(L_OP, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
